// File: rtl/pamac_pkg.sv
// Shared types for the PAMAC Booth sequencer: digit encoding and micro-op bundle.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pamac_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SHIFT_W    = 3;

    // One radix-4 Booth digit: magnitude-2 flag, sign and non-zero flag.
    typedef struct packed {
        logic mag2;
        logic neg;
        logic nz;
    } booth_digit_t;

    // One shifter/accumulator micro-op as presented to the datapath.
    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic               mag2;
        logic               neg;
        logic               zero;
        logic               first;
        logic               last;
    } pamac_op_t;

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth encoder: 16-bit signed weight to eight {mag2,neg,nz} digits.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module booth_r4_enc
    import pamac_pkg::*;
(
    input  logic [15:0]                   w_i,
    output booth_digit_t [NUM_DIGITS-1:0] dig_o
);

    // w extended with the implicit w[-1]=0 so every digit sees a full triplet.
    logic [16:0] wx;
    assign wx = {w_i, 1'b0};

    // Decode each triplet {w[2i+1], w[2i], w[2i-1]} into digit flags.
    always_comb begin
        logic [2:0] t;
        dig_o = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            t = wx[2*i +: 3];
            dig_o[i].nz   = !((t == 3'b000) || (t == 3'b111));
            dig_o[i].neg  = t[2] & ~(t[1] & t[0]);
            dig_o[i].mag2 = (t == 3'b011) || (t == 3'b100);
        end
    end

endmodule

// File: rtl/pamac_booth_sched.sv
// Booth-digit sequencer: one shifter/accumulator micro-op per (non-zero) digit.
// Latency: first op presented the cycle after weight acceptance, then 1 op/cycle.
// Backpressure: op fields hold while op_valid & !op_ready; w_ready only in IDLE or on the last firing op.
module pamac_booth_sched
    import pamac_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [2:0]        op_shift,
    output logic              op_mag2,
    output logic              op_neg,
    output logic              op_zero,
    output logic              op_first,
    output logic              op_last,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [NUM_DIGITS-1:0] mag2_q, mag2_d;
    logic [NUM_DIGITS-1:0] neg_q, neg_d;
    logic [NUM_DIGITS-1:0] nz_q, nz_d;
    logic                  first_q, first_d;

    booth_digit_t [NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0]         dig_nz, dig_mag2, dig_neg, load_mask;
    logic [SHIFT_W-1:0]            sel;
    logic                          one_left, fire, accept;
    pamac_op_t                     op;

    booth_r4_enc u_enc (
        .w_i   (w_data),
        .dig_o (dig)
    );

    // Flatten digit flags; an all-zero weight still needs one zero op at digit 0.
    always_comb begin
        dig_nz   = '0;
        dig_mag2 = '0;
        dig_neg  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_nz[i]   = dig[i].nz;
            dig_mag2[i] = dig[i].mag2;
            dig_neg[i]  = dig[i].neg;
        end
        if (!SKIP_ZERO)
            load_mask = '1;
        else if (dig_nz == '0)
            load_mask = 8'h01;
        else
            load_mask = dig_nz;
    end

    // Lowest set mask bit wins so digits issue in ascending shift order.
    always_comb begin
        sel = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask_q[i])
                sel = SHIFT_W'(i);
        end
    end

    assign one_left = (mask_q != '0) && ((mask_q & (mask_q - 8'd1)) == '0);
    assign op_valid = (state_q == ST_ISSUE) && !rst;
    assign fire     = op_valid & op_ready;
    assign busy     = (state_q != ST_IDLE);
    assign w_ready  = !rst && !flush &&
                      ((state_q == ST_IDLE) || (one_left && op_ready));
    assign accept   = w_valid & w_ready;

    // Build the presented op; every field is zero when nothing is offered.
    always_comb begin
        op = '0;
        if (op_valid) begin
            op.shift = sel;
            op.mag2  = mag2_q[sel];
            op.neg   = neg_q[sel];
            op.zero  = !nz_q[sel];
            op.first = first_q;
            op.last  = one_left;
        end
    end

    assign op_shift = op.shift;
    assign op_mag2  = op.mag2;
    assign op_neg   = op.neg;
    assign op_zero  = op.zero;
    assign op_first = op.first;
    assign op_last  = op.last;

    // Next state: flush beats fire and accept; accept on the last fire reloads without a bubble.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        mag2_d  = mag2_q;
        neg_d   = neg_q;
        nz_d    = nz_q;
        first_d = first_q;
        if (flush) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            first_d = 1'b0;
        end else if (accept) begin
            state_d = ST_ISSUE;
            mask_d  = load_mask;
            mag2_d  = dig_mag2;
            neg_d   = dig_neg;
            nz_d    = dig_nz;
            first_d = 1'b1;
        end else if (fire) begin
            mask_d[sel] = 1'b0;
            first_d     = 1'b0;
            if (one_left)
                state_d = ST_IDLE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            mag2_q  <= '0;
            neg_q   <= '0;
            nz_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            mag2_q  <= mag2_d;
            neg_q   <= neg_d;
            nz_q    <= nz_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_pamac_booth_sched.sv
// Directed bench for the Booth sequencer, including a SKIP_ZERO=0 instance.
// Latency: checks first op one cycle after acceptance.
// Backpressure: exercises stalls, back-to-back weights, flush and reset.
module tb_pamac_booth_sched;

    logic       clk = 1'b0;
    logic       rst, flush, w_valid, op_ready;
    logic [15:0] w_data;
    logic       w_ready, op_valid, op_mag2, op_neg, op_zero, op_first, op_last, busy;
    logic [2:0] op_shift;

    logic       flush2, w_valid2, op_ready2;
    logic [15:0] w_data2;
    logic       w_ready2, op_valid2, op_mag22, op_neg2, op_zero2, op_first2, op_last2, busy2;
    logic [2:0] op_shift2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pamac_booth_sched #(.DATA_W(16), .SKIP_ZERO(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .op_valid(op_valid), .op_ready(op_ready), .op_shift(op_shift),
        .op_mag2(op_mag2), .op_neg(op_neg), .op_zero(op_zero), .op_first(op_first),
        .op_last(op_last), .busy(busy)
    );

    pamac_booth_sched #(.DATA_W(16), .SKIP_ZERO(1'b0)) u_dut_nz (
        .clk(clk), .rst(rst), .flush(flush2), .w_valid(w_valid2), .w_ready(w_ready2),
        .w_data(w_data2), .op_valid(op_valid2), .op_ready(op_ready2), .op_shift(op_shift2),
        .op_mag2(op_mag22), .op_neg(op_neg2), .op_zero(op_zero2), .op_first(op_first2),
        .op_last(op_last2), .busy(busy2)
    );

    logic [8:0] obs, obs2;
    assign obs  = {op_valid,  op_shift,  op_mag2,  op_neg,  op_zero,  op_first,  op_last};
    assign obs2 = {op_valid2, op_shift2, op_mag22, op_neg2, op_zero2, op_first2, op_last2};

    // Expected op word {valid, shift, mag2, neg, zero, first, last}.
    function automatic logic [8:0] pk(input int sh, input bit m, input bit n,
                                      input bit z, input bit f, input bit l);
        return {1'b1, 3'(sh), m, n, z, f, l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] w);
        w_valid = 1'b1;
        w_data  = w;
        #1;
        chk("w_ready_on_offer", 32'(w_ready), 32'd1);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic expect_op(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'(obs), 32'(exp));
        tick();
    endtask

    task automatic expect_idle(input string tag);
        #1;
        chk(tag, {29'd0, op_valid, busy, w_ready}, 32'b001);
    endtask

    initial begin
        int idx, cyc;
        rst = 1'b1; flush = 1'b0; w_valid = 1'b0; op_ready = 1'b1; w_data = '0;
        flush2 = 1'b0; w_valid2 = 1'b0; op_ready2 = 1'b1; w_data2 = '0;
        tick(); tick();

        // Reset state
        chk("rst_outputs", {22'd0, w_ready, busy, obs}, 32'd0);
        chk("rst_outputs_nz", {22'd0, w_ready2, busy2, obs2}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_w_ready", 32'(w_ready), 32'd1);
        tick();

        // Single-digit weight
        offer(16'h0001);
        expect_op("w0001", pk(0, 0, 0, 0, 1, 1));
        expect_idle("idle_after_0001");

        // Two digits: -1 at 0, +1 at 1
        offer(16'h0003);
        #1;
        chk("busy_in_issue", 32'(busy), 32'd1);
        expect_op("w0003_op0", pk(0, 0, 1, 0, 1, 0));
        expect_op("w0003_op1", pk(1, 0, 0, 0, 0, 1));

        // Sign corners
        offer(16'h8000);
        expect_op("w8000", pk(7, 1, 1, 0, 1, 1));
        offer(16'hFFFF);
        expect_op("wFFFF", pk(0, 0, 1, 0, 1, 1));

        // Full weight, eight consecutive ops
        offer(16'h5555);
        for (int i = 0; i < 8; i++)
            expect_op("w5555", pk(i, 0, 0, 0, i == 0, i == 7));
        expect_idle("idle_after_5555");

        // Zero weight
        offer(16'h0000);
        expect_op("w0000", pk(0, 0, 0, 1, 1, 1));
        expect_idle("idle_after_0000");

        // SKIP_ZERO=0 instance issues all eight digits
        w_valid2 = 1'b1; w_data2 = 16'h0001;
        #1;
        chk("nz_w_ready", 32'(w_ready2), 32'd1);
        tick();
        w_valid2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("nz_w0001", 32'(obs2), 32'(pk(i, 0, 0, i != 0, i == 0, i == 7)));
            tick();
        end
        #1;
        chk("nz_idle", {30'd0, op_valid2, busy2}, 32'd0);

        // Backpressure with ready 1,0,0,1,... and a back-to-back weight on the last fire
        offer(16'h5555);
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            op_ready = (cyc % 3 == 0);
            if (idx == 7 && op_ready) begin
                w_valid = 1'b1;
                w_data  = 16'h0001;
            end
            #1;
            chk("bp_op", 32'(obs), 32'(pk(idx, 0, 0, 0, idx == 0, idx == 7)));
            if (idx == 7 && op_ready)
                chk("bp_b2b_accept", 32'(w_ready), 32'd1);
            if (op_ready)
                idx++;
            tick();
            w_valid = 1'b0;
            cyc++;
        end
        chk("bp_all_fired", 32'(idx), 32'd8);
        op_ready = 1'b1;
        expect_op("b2b_no_bubble", pk(0, 0, 0, 0, 1, 1));
        expect_idle("idle_after_b2b");

        // Flush after the third op
        offer(16'h5555);
        for (int i = 0; i < 3; i++)
            expect_op("pre_flush", pk(i, 0, 0, 0, i == 0, 0));
        flush = 1'b1;
        #1;
        chk("flush_w_ready", 32'(w_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("post_flush", {29'd0, op_valid, busy, op_last}, 32'd0);
        offer(16'h0003);
        expect_op("flush_w0003_op0", pk(0, 0, 1, 0, 1, 0));
        expect_op("flush_w0003_op1", pk(1, 0, 0, 0, 0, 1));

        // Reset after the third op
        offer(16'h5555);
        for (int i = 0; i < 3; i++)
            expect_op("pre_rst", pk(i, 0, 0, 0, i == 0, 0));
        rst = 1'b1;
        #1;
        chk("rst_mid_w_ready", 32'(w_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst", {29'd0, op_valid, busy, op_last}, 32'd0);
        offer(16'h0003);
        expect_op("rst_w0003_op0", pk(0, 0, 1, 0, 1, 0));
        expect_op("rst_w0003_op1", pk(1, 0, 0, 0, 0, 1));
        expect_idle("final_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pamac_booth_sched.md
Name: pamac_booth_sched

Overview:
- Sequencing controller for the PAMAC 16-bit partial-product left shifter. The shifter's 3-bit shift control selects a left shift of 0, 2, 4 … 14.
- Accepts one signed 16-bit weight per transaction and radix-4 Booth-encodes it into 8 digits d_i in {-2,-1,0,+1,+2}.
- Issues one shifter/accumulator micro-op per non-zero digit, skipping zero digits so the MAC takes fewer cycles.
- Sits between the weight buffer (valid/ready in) and the shifter + accumulator datapath (valid/ready out).

Parameters:
- DATA_W, 16, weight width. Must be 16: the shifter supports exactly 8 radix-4 digit positions.
- SKIP_ZERO, 1. 1 = skip zero digits; 0 = issue all 8 digits, zero digits flagged op_zero=1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous cancel of the current weight
- w_valid  in  1  weight offered
- w_ready  out  1  weight accepted when w_valid & w_ready
- w_data  in  16  signed weight
- op_valid  out  1  micro-op present
- op_ready  in  1  datapath consumes micro-op
- op_shift  out  3  digit index i; drives the shifter control (shift = 2*i)
- op_mag2  out  1  |d_i| = 2; datapath adds extra <<1
- op_neg  out  1  d_i < 0; datapath subtracts
- op_zero  out  1  no accumulate (all-zero weight, or SKIP_ZERO=0 with d_i=0)
- op_first  out  1  first op of weight; accumulator clears before adding
- op_last  out  1  last op of weight
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - State returns to IDLE and the mask clears.
  - Outputs: op_valid=0, busy=0, w_ready=0 during rst, then 1 in IDLE. All op_* fields are 0.
  - Reset mid-transaction drops the weight without emitting op_last.
- Booth encoding:
  - d_i = -2*w[2i+1] + w[2i] + w[2i-1], with w[-1]=0, for i = 0..7.
  - Encoding is registered at acceptance: mask[7:0] (d_i != 0, or all ones when SKIP_ZERO=0), plus per-digit mag2/neg.
- FSM states: IDLE, ISSUE.
  - IDLE: w_ready=1, op_valid=0. On accept, latch the encoding and go to ISSUE.
  - IDLE → ISSUE: the first op is presented the cycle after acceptance (latency 1).
  - ISSUE: op_valid=1. The presented op is the lowest set bit of mask, chosen by a priority encoder, so op_shift is ascending.
  - ISSUE outputs are stable while op_valid & !op_ready; no field may change during a stall.
  - On fire (op_valid & op_ready), clear that mask bit.
  - op_first=1 on the first op of a weight. op_last=1 when exactly one mask bit remains.
- All-zero mask (weight 0, SKIP_ZERO=1): ISSUE emits one op with op_zero=1, op_first=op_last=1, op_shift=0.
- Back-to-back weights:
  - In ISSUE, w_ready = op_last & op_ready.
  - A weight accepted on the same cycle the last op fires reloads the mask and stays in ISSUE with no bubble.
  - Otherwise, the last fire returns the FSM to IDLE.
- flush:
  - Forces IDLE next cycle and clears the mask. w_ready=0 on the flush cycle.
  - Flush has priority over an op fire and over weight acceptance in the same cycle. An op fire in that cycle still completes on the datapath side.
- Throughput: one op per cycle under op_ready=1. A weight costs max(1, popcount(mask)) cycles, at most 8.

Decomposition:
- Package pamac_pkg:
  - NUM_DIGITS=8 and SHIFT_W=3.
  - Typedef booth_digit_t {mag2, neg, nz}.
  - Typedef pamac_op_t {shift, mag2, neg, zero, first, last}.
- Sub-module booth_r4_enc: combinational, 16-bit weight → booth_digit_t[8]. Shared with verification models.
- Priority encoder and FSM stay inline.

Test Plan:
- Single weight: w=0x0001, op_ready=1 → one op: shift=0, mag2=0, neg=0, first=last=1, op_valid 1 cycle after accept.
- Multi-digit weight: w=0x0003 → op(shift=0, neg=1, mag2=0, first=1), then op(shift=1, neg=0, mag2=0, last=1).
- Sign corner: w=0x8000 → one op: shift=7, mag2=1, neg=1, first=last=1. w=0xFFFF → one op: shift=0, neg=1, mag2=0.
- Full weight and zero weight:
  - w=0x5555 → 8 ops, shift 0..7, all mag2=0, neg=0, 8 consecutive cycles.
  - w=0x0000 → one op with zero=1, first=last=1.
  - SKIP_ZERO=0, w=0x0001 → 8 ops: shift0 zero=0; shifts 1..7 zero=1.
- Backpressure and pipelining:
  - w=0x5555 with op_ready toggling 1,0,0,1… → fields hold during stalls, shift sequence unchanged.
  - Next w=0x0001 presented during the last op → accepted that cycle; its op follows with no idle cycle.
- flush / reset: flush after the 3rd op of 0x5555 → op_valid=0 next cycle, busy=0, no op_last. Then w=0x0003 produces the normal 2-op sequence. Same check with rst instead of flush.
